// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scan-code-set-2 key encoder: prefix bytes,
// ignorable device responses, deframer states and ps2_key bit positions.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_OVR_0  = 8'h00;
  localparam logic [7:0] PS2_OVR_F  = 8'hFF;

  // Pause/Break sends E1 followed by seven more bytes that carry no key event.
  localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic ps2_is_ignored(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    case (b)
      PS2_ACK, PS2_BAT_OK, PS2_ECHO, PS2_RESEND, PS2_OVR_0, PS2_OVR_F: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receive front end: 2-flop sync and debounce on both lines, 11-bit frame
// deframer with odd-parity/start/stop checking and an inter-edge timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_vld,
  output logic [7:0] byte_dat,
  output logic       frame_err
);

  localparam int              TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]      FILT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          clk_filt_q, clk_filt_d;
  logic          dat_filt_q, dat_filt_d;
  logic [7:0]    clk_cnt_q, clk_cnt_d;
  logic [7:0]    dat_cnt_q, dat_cnt_d;
  logic          fall_stb_q, fall_stb_d;
  rx_state_e     state_q, state_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frame_err_q, frame_err_d;

  // Line conditioning: a level is accepted only after FILTER_LEN stable cycles.
  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_data};

    clk_filt_d = clk_filt_q;
    clk_cnt_d  = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_cnt_q == FILT_LAST) clk_filt_d = clk_sync_q[1];
      else                        clk_cnt_d  = clk_cnt_q + 8'd1;
    end

    dat_filt_d = dat_filt_q;
    dat_cnt_d  = '0;
    if (dat_sync_q[1] != dat_filt_q) begin
      if (dat_cnt_q == FILT_LAST) dat_filt_d = dat_sync_q[1];
      else                        dat_cnt_d  = dat_cnt_q + 8'd1;
    end

    fall_stb_d = clk_filt_q & ~clk_filt_d;
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;

    if (state_q == ST_IDLE || fall_stb_q) tmo_d = '0;
    else                                  tmo_d = tmo_q + 1'b1;

    if (state_q != ST_IDLE && !fall_stb_q && tmo_q == TMO_LAST) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end else if (fall_stb_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!dat_filt_q) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_filt_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = dat_filt_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // Odd parity: data plus parity bit must hold an odd number of ones.
          if (dat_filt_q && (^{shift_q, par_q})) byte_vld_d  = 1'b1;
          else                                   frame_err_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      clk_filt_q  <= 1'b1;
      dat_filt_q  <= 1'b1;
      clk_cnt_q   <= '0;
      dat_cnt_q   <= '0;
      fall_stb_q  <= 1'b0;
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_filt_q  <= clk_filt_d;
      dat_filt_q  <= dat_filt_d;
      clk_cnt_q   <= clk_cnt_d;
      dat_cnt_q   <= dat_cnt_d;
      fall_stb_q  <= fall_stb_d;
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign byte_vld  = byte_vld_q;
  assign byte_dat  = shift_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 stream to 11-bit toggle-event word {toggle, pressed, extended, code}.
// Define PS2_REPEAT_FILTER_EN to suppress typematic repeats of the last make code.
module ps2_key_encoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic       rx_vld;
  logic [7:0] rx_byte;
  logic       rx_err;

  ps2_rx_frame #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_vld (rx_vld),
    .byte_dat (rx_byte),
    .frame_err(rx_err)
  );

  logic [10:0] key_q, key_d;
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic [2:0]  skip_q, skip_d;
  logic        emit;

`ifdef PS2_REPEAT_FILTER_EN
  logic       last_vld_q, last_vld_d;
  logic       last_ext_q, last_ext_d;
  logic [7:0] last_code_q, last_code_d;
  logic       last_match;
`endif

  always_comb begin
    key_d  = key_q;
    ext_d  = ext_q;
    brk_d  = brk_q;
    skip_d = skip_q;
    emit   = 1'b0;
`ifdef PS2_REPEAT_FILTER_EN
    last_vld_d  = last_vld_q;
    last_ext_d  = last_ext_q;
    last_code_d = last_code_q;
    last_match  = last_vld_q && (last_ext_q == ext_q) && (last_code_q == rx_byte);
`endif

    if (rx_err) begin
      ext_d  = 1'b0;
      brk_d  = 1'b0;
      skip_d = '0;
    end else if (rx_vld) begin
      if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (rx_byte == PS2_PAUSE) begin
        skip_d = PS2_PAUSE_SKIP;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end else if (!ps2_is_ignored(rx_byte)) begin
        emit = 1'b1;
`ifdef PS2_REPEAT_FILTER_EN
        if (!brk_q) begin
          if (last_match) begin
            emit = 1'b0;
          end else begin
            last_vld_d  = 1'b1;
            last_ext_d  = ext_q;
            last_code_d = rx_byte;
          end
        end else if (last_match) begin
          last_vld_d = 1'b0;
        end
`endif
        if (emit) key_d = {~key_q[KEY_TOGGLE], ~brk_q, ext_q, rx_byte};
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_q  <= '0;
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      skip_q <= '0;
`ifdef PS2_REPEAT_FILTER_EN
      last_vld_q  <= 1'b0;
      last_ext_q  <= 1'b0;
      last_code_q <= '0;
`endif
    end else begin
      key_q  <= key_d;
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      skip_q <= skip_d;
`ifdef PS2_REPEAT_FILTER_EN
      last_vld_q  <= last_vld_d;
      last_ext_q  <= last_ext_d;
      last_code_q <= last_code_d;
`endif
    end
  end

  assign ps2_key   = key_q;
  assign frame_err = rx_err;

endmodule
